// File: rtl/mem_request_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_request_master
// Description : Accepts single read/write commands from a requester, drives
//               one start-strobed operation on a latency-fixed memory, waits
//               the configured number of cycles and returns a one-cycle
//               completion pulse carrying the read data. A separate RAM-clear
//               request holds clrRAM high for CLR_LAT cycles.
// Ports       : clk, rst                      clock / sync active-high reset
//               req_valid/req_ready           command handshake
//               req_write, req_indirect,
//               req_addr, req_wdata           command fields
//               clr_req                       RAM-clear request
//               rsp_valid, rsp_write,
//               rsp_rdata                     completion
//               busy                          block is not idle
//               start, cntrl, addr, dataIn,
//               isIndirect, clrRAM, dataOut   memory side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_request_master #(
    parameter int DIRECT_LAT   = 2,
    parameter int INDIRECT_LAT = 4,
    parameter int CLR_LAT      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_indirect,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       clr_req,
    output logic       rsp_valid,
    output logic       rsp_write,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       start,
    output logic [1:0] cntrl,
    output logic [7:0] addr,
    output logic [7:0] dataIn,
    output logic       isIndirect,
    output logic       clrRAM,
    input  logic [7:0] dataOut
);

    // A latency of 0 is treated as 1 so WAIT/CLEAR always last at least a cycle.
    localparam logic [3:0] c_DIRECT_LAT   = (DIRECT_LAT   == 0) ? 4'd1 : 4'(DIRECT_LAT);
    localparam logic [3:0] c_INDIRECT_LAT = (INDIRECT_LAT == 0) ? 4'd1 : 4'(INDIRECT_LAT);
    localparam logic [3:0] c_CLR_LAT      = (CLR_LAT      == 0) ? 4'd1 : 4'(CLR_LAT);

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;
    localparam logic [1:0] c_OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_cnt;
    logic       r_write;
    logic       r_indirect;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [1:0] r_cntrl;
    logic [7:0] r_rdata;

    logic       w_ready;
    logic       w_start;
    logic       w_clr;
    logic       w_rsp_valid;

    // ------------------------------------------------------------------
    // Next-state and state-decoded strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_start     = 1'b0;
        w_clr       = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A clear request blocks acceptance; any command stays pending.
                w_ready = ~clr_req;
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                end else if (req_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                w_clr = 1'b1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register, command latch, counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_indirect <= 1'b0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_cntrl    <= c_OP_NOP;
            r_rdata    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_cnt <= c_CLR_LAT;
                    end else if (req_valid) begin
                        // Operation code is registered here so it is already
                        // valid during the ISSUE cycle and held through WAIT.
                        r_write    <= req_write;
                        r_indirect <= req_indirect;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_cntrl    <= req_write ? c_OP_WRITE : c_OP_READ;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_indirect ? c_INDIRECT_LAT : c_DIRECT_LAT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        // Last WAIT cycle: memory data is valid now.
                        r_rdata <= r_write ? 8'h00 : dataOut;
                        r_cntrl <= c_OP_NOP;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = w_ready;
    assign start      = w_start;
    assign clrRAM     = w_clr;
    assign rsp_valid  = w_rsp_valid;
    assign rsp_write  = r_write;
    assign rsp_rdata  = r_rdata;
    assign busy       = (r_state != S_IDLE);
    assign cntrl      = r_cntrl;
    assign addr       = r_addr;
    assign dataIn     = r_wdata;
    assign isIndirect = r_indirect;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_request_master
// Description : Scoreboard bench for mem_request_master. A behavioural RAM
//               answers the memory side; directed commands push their
//               expected completion (write flag, read data, cycle) into a
//               queue and a monitor pops/compares on every rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_request_master;

    localparam int c_DLAT = 2;
    localparam int c_ILAT = 4;
    localparam int c_CLAT = 1;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic       req_indirect;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       clr_req;
    logic       rsp_valid;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       start;
    logic [1:0] cntrl;
    logic [7:0] addr;
    logic [7:0] dataIn;
    logic       isIndirect;
    logic       clrRAM;
    logic [7:0] dataOut;

    mem_request_master #(
        .DIRECT_LAT   (c_DLAT),
        .INDIRECT_LAT (c_ILAT),
        .CLR_LAT      (c_CLAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_indirect (req_indirect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .clr_req      (clr_req),
        .rsp_valid    (rsp_valid),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .start        (start),
        .cntrl        (cntrl),
        .addr         (addr),
        .dataIn       (dataIn),
        .isIndirect   (isIndirect),
        .clrRAM       (clrRAM),
        .dataOut      (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge = number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: write on start+write, cleared by clrRAM.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (clrRAM) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (start && cntrl == 2'b10) begin
            mem[addr] <= dataIn;
        end
    end
    assign dataOut = mem[addr];

    typedef struct {
        logic       w;
        logic [7:0] d;
        int         cyc;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(e.w));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_cntrl", 32'(cntrl), 32'd0);
            end
        end
    end

    // Issue one command starting between a negedge and the next posedge.
    // Returns the cycle in which the handshake completed; the completion
    // is expected LAT+2 cycles after that handshake cycle.
    task automatic send(input logic w, input logic ind, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_d,
                        input bit hold, output int hs);
        int t;
        int lat;
        lat          = ind ? c_ILAT : c_DLAT;
        req_write    = w;
        req_indirect = ind;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        #1;
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        if (req_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got req_ready=%b, expected 1", req_ready);
            req_valid = 1'b0;
            hs = -1;
            return;
        end
        hs = cyc;
        q.push_back('{w, exp_d, cyc + lat + 2});
        @(negedge clk); #1;
        if (!hold) req_valid = 1'b0;
        chk("issue_start",  32'(start),      32'd1);
        chk("issue_cntrl",  32'(cntrl),      w ? 32'd2 : 32'd1);
        chk("issue_addr",   32'(addr),       32'(a));
        chk("issue_dataIn", 32'(dataIn),     32'(d));
        chk("issue_ind",    32'(isIndirect), 32'(ind));
        for (int i = 0; i < lat; i++) begin
            @(negedge clk); #1;
            chk("wait_start", 32'(start),      32'd0);
            chk("wait_cntrl", 32'(cntrl),      w ? 32'd2 : 32'd1);
            chk("wait_ind",   32'(isIndirect), 32'(ind));
            chk("wait_addr",  32'(addr),       32'(a));
            chk("wait_ready", 32'(req_ready),  32'd0);
        end
    endtask

    initial begin
        int h1, h2, h3, c0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_indirect = 1'b0;
        req_addr     = 8'h00;
        req_wdata    = 8'h00;
        clr_req      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_start",  32'(start),      32'd0);
        chk("rst_cntrl",  32'(cntrl),      32'd0);
        chk("rst_addr",   32'(addr),       32'd0);
        chk("rst_dataIn", 32'(dataIn),     32'd0);
        chk("rst_ind",    32'(isIndirect), 32'd0);
        chk("rst_clrRAM", 32'(clrRAM),     32'd0);
        chk("rst_rspv",   32'(rsp_valid),  32'd0);
        chk("rst_rdata",  32'(rsp_rdata),  32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Direct write then read, indirect write then read
        send(1'b1, 1'b0, 8'h10, 8'hA5, 8'h00, 1'b0, h1);
        send(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, h1);
        send(1'b1, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b0, h1);
        send(1'b0, 1'b1, 8'h20, 8'h00, 8'h3C, 1'b0, h1);

        // Clear and read request together: clear wins, read waits
        repeat (2) @(negedge clk);
        #1;
        clr_req      = 1'b1;
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_indirect = 1'b0;
        req_addr     = 8'h10;
        #1;
        chk("clr_ready_idle", 32'(req_ready), 32'd0);
        c0 = cyc;
        @(negedge clk); #1;
        chk("clr_clrRAM", 32'(clrRAM),    32'd1);
        chk("clr_ready",  32'(req_ready), 32'd0);
        chk("clr_cntrl",  32'(cntrl),     32'd0);
        chk("clr_start",  32'(start),     32'd0);
        chk("clr_busy",   32'(busy),      32'd1);
        @(negedge clk); #1;
        chk("clr_done_clrRAM", 32'(clrRAM), 32'd0);
        chk("clr_done_busy",   32'(busy),   32'd0);
        clr_req = 1'b0;
        send(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, h1);
        chk("clr_pending_accept", h1, c0 + 2);

        // Reset during the second WAIT cycle of an indirect read
        repeat (2) @(negedge clk);
        #1;
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_indirect = 1'b1;
        req_addr     = 8'h20;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_start",  32'(start),      32'd0);
        chk("abort_cntrl",  32'(cntrl),      32'd0);
        chk("abort_addr",   32'(addr),       32'd0);
        chk("abort_ind",    32'(isIndirect), 32'd0);
        chk("abort_rdata",  32'(rsp_rdata),  32'd0);
        chk("abort_rspv",   32'(rsp_valid),  32'd0);
        chk("abort_busy",   32'(busy),       32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        repeat (10) @(negedge clk);
        #1;

        // Back-to-back reads with req_valid held high
        send(1'b1, 1'b0, 8'h11, 8'hC3, 8'h00, 1'b0, h1);
        send(1'b0, 1'b0, 8'h11, 8'h00, 8'hC3, 1'b1, h1);
        send(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, h2);
        send(1'b0, 1'b0, 8'h11, 8'h00, 8'hC3, 1'b0, h3);
        chk("b2b_spacing_1", h2 - h1, 32'd5);
        chk("b2b_spacing_2", h3 - h2, 32'd5);

        repeat (8) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_request_master.md
MEM_REQUEST_MASTER -- requirements
Module: mem_request_master

Interface
REQ-001 Parameter DIRECT_LAT, default 2, SHALL set the WAIT cycles for a direct access (legal 1..15).
REQ-002 Parameter INDIRECT_LAT, default 4, SHALL set the WAIT cycles for an indirect access (legal 1..15).
REQ-003 Parameter CLR_LAT, default 1, SHALL set the number of cycles clrRAM is held high (legal 1..15).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port list (name  direction  width  meaning):
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-high reset
  req_valid  in  1  requester has a command
  req_ready  out  1  master accepts a command this cycle
  req_write  in  1  1 = write, 0 = read
  req_indirect  in  1  indirect-addressing access
  req_addr  in  8  target address
  req_wdata  in  8  write data
  clr_req  in  1  request a RAM clear
  rsp_valid  out  1  one-cycle completion pulse
  rsp_write  out  1  completed command was a write
  rsp_rdata  out  8  read data (0 for writes)
  busy  out  1  state != IDLE
  start  out  1  memory start strobe
  cntrl  out  2  memory op: 00 nop, 01 read, 10 write (11 never driven)
  addr  out  8  memory address
  dataIn  out  8  memory write data
  isIndirect  out  1  memory indirect flag
  clrRAM  out  1  memory clear
  dataOut  in  8  memory read data

Function
REQ-006 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, RESP, CLEAR.
REQ-007 req_ready SHALL be combinational: (state == IDLE) and not clr_req.
REQ-008 IDLE + clr_req: next state CLEAR; clr_req SHALL win over a simultaneous req_valid, which stays pending.
REQ-009 IDLE + req_valid + req_ready: latch req_write, req_indirect, req_addr, req_wdata; next state ISSUE.
REQ-010 ISSUE SHALL last one cycle: start = 1; cntrl = 10 for writes, 01 for reads; addr, dataIn, isIndirect from the latched values; load a 4-bit counter with INDIRECT_LAT if indirect, else DIRECT_LAT.
REQ-011 WAIT: start = 0; addr, dataIn, isIndirect and cntrl SHALL hold their ISSUE values; the counter SHALL decrement each cycle.
REQ-012 Leaving WAIT: in the WAIT cycle with counter == 1, dataOut SHALL be registered (reads only) and the next state SHALL be RESP. WAIT therefore lasts exactly LAT cycles.
REQ-013 RESP SHALL last one cycle:
  - rsp_valid = 1
  - rsp_write = the latched req_write
  - rsp_rdata = the captured data for reads, 8'h00 for writes
  - cntrl = 00
  - next state IDLE
REQ-014 Latency: accept-edge to rsp_valid SHALL be LAT+2 cycles; back-to-back throughput SHALL be one command per LAT+3 cycles.
REQ-015 CLEAR: clrRAM = 1 for exactly CLR_LAT consecutive cycles, cntrl = 00, start = 0; then IDLE. No rsp_valid is generated for a clear.
REQ-016 A clr_req arriving outside IDLE SHALL be ignored. The requester holds clr_req until busy = 0.
REQ-017 rsp_valid SHALL never be high in any state other than RESP.
REQ-018 rsp_rdata SHALL hold its value until the next RESP.
REQ-019 A parameter value of 0 SHALL behave as 1.

Reset
REQ-020 While rst = 1 at a clock edge:
  - state becomes IDLE
  - start, cntrl, addr, dataIn, isIndirect, clrRAM, rsp_valid, rsp_write, rsp_rdata and the counter become 0
REQ-021 rst SHALL have priority over all other inputs.
REQ-022 rst asserted in ISSUE, WAIT, RESP or CLEAR SHALL abandon the operation: no rsp_valid is produced, and clrRAM drops on the next edge.
REQ-023 req_ready SHALL be 1 in the first cycle after rst deasserts, if clr_req = 0.

Verification
REQ-024 Direct write then read:
  - write addr 8'h10, data 8'hA5 -> start pulses 1 cycle with cntrl 10; rsp_valid 4 cycles after accept, rsp_rdata 00
  - read 8'h10 -> cntrl 01; rsp_rdata A5 4 cycles after accept
REQ-025 Indirect read of addr 8'h20 with dataOut driven 8'h3C -> isIndirect 1 and held through WAIT; rsp_valid exactly 6 cycles after accept; rsp_rdata 3C.
REQ-026 clr_req and req_valid asserted together in IDLE -> clrRAM high exactly 1 cycle, req_ready 0 during CLEAR; the pending request is accepted the cycle after return to IDLE.
REQ-027 rst pulsed during the second WAIT cycle of an indirect read -> all outputs 0 next cycle, no rsp_valid ever, req_ready 1 after rst drops.
REQ-028 req_valid held high continuously for 3 direct reads -> exactly 3 rsp_valid pulses spaced 5 cycles apart; req_ready is high only in IDLE.
